// File: rtl/sound_cmd_tx.sv
// Sound command transmitter: buffers main-CPU command bytes in a small FIFO and
// hands them one at a time to the sound-side latch, waiting for an acknowledge.
module sound_cmd_tx #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16384
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       paused,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_din,
    input  logic       flush,
    input  logic       err_clr,
    output logic       latch_wr,
    output logic [7:0] latch_din,
    input  logic       snd_ack,
    output logic       busy,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic [4:0] count,
    output logic       overflow,
    output logic       timeout_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [4:0]    count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    latch_din_q, latch_din_d;
    logic          overflow_q, overflow_d;
    logic          timeout_err_q, timeout_err_d;
    logic [7:0]    mem_q [DEPTH];

    logic       push;
    logic       pop;
    logic       ovf_evt;
    logic       to_evt;
    logic [7:0] head;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        timer_d       = timer_q;
        latch_din_d   = latch_din_q;
        overflow_d    = overflow_q;
        timeout_err_d = timeout_err_q;
        push          = 1'b0;
        pop           = 1'b0;
        ovf_evt       = 1'b0;
        to_evt        = 1'b0;

        if (flush) begin
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            timer_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((count_q != 5'd0) && !paused) begin
                        state_d = SEND;
                    end
                end
                SEND: begin
                    pop         = 1'b1;
                    latch_din_d = head;
                    timer_d     = '0;
                    state_d     = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (snd_ack) begin
                        state_d = IDLE;
                    end else if (!paused) begin
                        timer_d = timer_q + 1'b1;
                        if (timer_d == TW'(ACK_TIMEOUT - 1)) begin
                            to_evt  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // A pop in the same cycle frees the slot the write lands in.
            if (cpu_wr) begin
                if ((count_q < 5'(DEPTH)) || pop) begin
                    push = 1'b1;
                end else begin
                    ovf_evt = 1'b1;
                end
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            count_d = count_q + {4'd0, push} - {4'd0, pop};
        end

        if (err_clr) begin
            overflow_d    = 1'b0;
            timeout_err_d = 1'b0;
        end
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end
        if (to_evt) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            timer_q       <= '0;
            latch_din_q   <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            latch_din_q   <= latch_din_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cpu_din;
        end
    end

    // The head byte is presented live in the SEND cycle and held afterwards.
    assign latch_wr    = (state_q == SEND) && !flush;
    assign latch_din   = latch_wr ? head : latch_din_q;
    assign busy        = (state_q != IDLE);
    assign fifo_full   = (count_q == 5'(DEPTH));
    assign fifo_empty  = (count_q == 5'd0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sound_cmd_tx.sv
// Directed bench for sound_cmd_tx: a scoreboard queue holds the bytes expected on
// the latch, popped by a monitor on every latch_wr.
`timescale 1ns/1ps
module tb_sound_cmd_tx;

    logic       clk;
    logic       reset_n;
    logic       paused;
    logic       cpu_wr;
    logic [7:0] cpu_din;
    logic       flush;
    logic       err_clr;
    logic       latch_wr;
    logic [7:0] latch_din;
    logic       snd_ack;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] count;
    logic       overflow;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb_q[$];

    sound_cmd_tx #(.DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .paused     (paused),
        .cpu_wr     (cpu_wr),
        .cpu_din    (cpu_din),
        .flush      (flush),
        .err_clr    (err_clr),
        .latch_wr   (latch_wr),
        .latch_din  (latch_din),
        .snd_ack    (snd_ack),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .count      (count),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit accept);
        cpu_wr  = 1'b1;
        cpu_din = b;
        if (accept) sb_q.push_back(b);
        cyc();
        cpu_wr = 1'b0;
    endtask

    // From WAIT_ACK: ack, IDLE, SEND (next byte on the latch), back in WAIT_ACK.
    task automatic ack_step(input string tag);
        snd_ack = 1'b1;
        cyc();
        snd_ack = 1'b0;
        chk({tag, "_idle_after_ack"}, busy, 1'b0);
        chk({tag, "_no_wr_after_ack"}, latch_wr, 1'b0);
        cyc();
        chk({tag, "_send"}, latch_wr, 1'b1);
        cyc();
    endtask

    task automatic final_ack(input string tag);
        snd_ack = 1'b1;
        cyc();
        snd_ack = 1'b0;
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_empty"}, fifo_empty, 1'b1);
        chk({tag, "_full"}, fifo_full, 1'b0);
        chk({tag, "_count"}, count, 5'd0);
        chk({tag, "_latch_wr"}, latch_wr, 1'b0);
        chk({tag, "_latch_din"}, latch_din, 8'h00);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_timeout"}, timeout_err, 1'b0);
    endtask

    always @(negedge clk) begin
        if (reset_n && latch_wr) begin
            if (sb_q.size() == 0) begin
                chk("spurious_latch_wr", latch_wr, 1'b0);
            end else begin
                chk("latch_din_order", latch_din, sb_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        paused  = 1'b0;
        cpu_wr  = 1'b0;
        cpu_din = 8'h00;
        flush   = 1'b0;
        err_clr = 1'b0;
        snd_ack = 1'b0;
        repeat (3) cyc();
        chk_reset_vals("por");
        reset_n = 1'b1;
        cyc();

        // Single command latency and ack handshake
        wr_byte(8'h12, 1'b1);
        chk("s1_count", count, 5'd1);
        chk("s1_no_wr_yet", latch_wr, 1'b0);
        cyc();
        chk("s1_latch_wr", latch_wr, 1'b1);
        chk("s1_latch_din", latch_din, 8'h12);
        chk("s1_busy_send", busy, 1'b1);
        cyc();
        chk("s1_wr_one_cycle", latch_wr, 1'b0);
        chk("s1_busy_wait", busy, 1'b1);
        chk("s1_din_held", latch_din, 8'h12);
        final_ack("s1");
        chk("s1_din_after_ack", latch_din, 8'h12);

        // Back-to-back writes fill the FIFO, sixth write overflows
        for (int i = 1; i <= 5; i++) wr_byte(8'(i), 1'b1);
        chk("s2_count_full", count, 5'd4);
        chk("s2_full", fifo_full, 1'b1);
        chk("s2_no_overflow", overflow, 1'b0);
        wr_byte(8'h06, 1'b0);
        chk("s2_overflow", overflow, 1'b1);
        chk("s2_count_kept", count, 5'd4);
        for (int i = 0; i < 4; i++) ack_step("s2");
        final_ack("s2");
        chk("s2_empty", fifo_empty, 1'b1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("s2_ovf_cleared", overflow, 1'b0);

        // Ack timeout, then paused extension and err_clr priority
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'hA1, 1'b1);
        chk("s3_send_a0", latch_wr, 1'b1);
        repeat (15) cyc();
        chk("s3_no_timeout_yet", timeout_err, 1'b0);
        chk("s3_still_waiting", busy, 1'b1);
        cyc();
        chk("s3_timeout", timeout_err, 1'b1);
        chk("s3_idle_after_to", busy, 1'b0);
        cyc();
        chk("s3_send_a1", latch_wr, 1'b1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("s3_to_cleared", timeout_err, 1'b0);
        cyc();
        paused = 1'b1;
        repeat (5) cyc();
        paused = 1'b0;
        repeat (13) cyc();
        chk("s3_paused_no_to", timeout_err, 1'b0);
        chk("s3_paused_waiting", busy, 1'b1);
        err_clr = 1'b1;
        cyc();
        chk("s3_to_beats_clr", timeout_err, 1'b1);
        chk("s3_idle_after_to2", busy, 1'b0);
        cyc();
        err_clr = 1'b0;
        chk("s3_to_cleared2", timeout_err, 1'b0);

        // Write into a full FIFO coinciding with the SEND pop
        paused = 1'b1;
        for (int i = 0; i < 4; i++) wr_byte(8'hB0 + 8'(i), 1'b1);
        chk("s4_full", fifo_full, 1'b1);
        chk("s4_paused_idle", busy, 1'b0);
        paused = 1'b0;
        cyc();
        chk("s4_send", latch_wr, 1'b1);
        wr_byte(8'hB4, 1'b1);
        chk("s4_count_stays", count, 5'd4);
        chk("s4_no_overflow", overflow, 1'b0);
        for (int i = 0; i < 4; i++) ack_step("s4");
        final_ack("s4");

        // Flush during WAIT_ACK with three queued
        paused = 1'b1;
        for (int i = 0; i < 4; i++) wr_byte(8'hC0 + 8'(i), 1'b1);
        paused = 1'b0;
        cyc();
        chk("s5_send_c0", latch_din, 8'hC0);
        cyc();
        chk("s5_three_queued", count, 5'd3);
        flush   = 1'b1;
        cpu_wr  = 1'b1;
        cpu_din = 8'hFF;
        cyc();
        flush  = 1'b0;
        cpu_wr = 1'b0;
        sb_q.delete();
        chk("s5_count0", count, 5'd0);
        chk("s5_busy0", busy, 1'b0);
        chk("s5_empty", fifo_empty, 1'b1);
        chk("s5_no_overflow", overflow, 1'b0);
        chk("s5_din_kept", latch_din, 8'hC0);
        repeat (20) cyc();
        chk("s5_no_timeout", timeout_err, 1'b0);
        chk("s5_still_idle", busy, 1'b0);
        chk("s5_din_kept2", latch_din, 8'hC0);

        // Asynchronous reset in WAIT_ACK
        wr_byte(8'hD0, 1'b1);
        wr_byte(8'hD1, 1'b1);
        chk("s6_send", latch_wr, 1'b1);
        cyc();
        chk("s6_waiting", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("s6_async");
        sb_q.delete();
        repeat (2) cyc();
        #3;
        reset_n = 1'b1;
        repeat (20) cyc();
        chk("s6_idle_after_rel", busy, 1'b0);
        chk("s6_count_after_rel", count, 5'd0);
        wr_byte(8'hE0, 1'b1);
        cyc();
        chk("s6_new_send", latch_wr, 1'b1);
        chk("s6_new_din", latch_din, 8'hE0);
        cyc();
        final_ack("s6");

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_cmd_tx.md
SOUND_CMD_TX -- requirements
Module: sound_cmd_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16384, meaning the number of non-paused clk cycles to wait for an acknowledge before giving up.
REQ-003 SHALL have port clk, input, 1, the single system clock (40M); all logic is in this one clock domain.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port paused, input, 1, which freezes command issue and the timeout counter.
REQ-006 SHALL have port cpu_wr, input, 1, a one-cycle strobe for a main-CPU write to the sound command port.
REQ-007 SHALL have port cpu_din, input, 8, the command byte qualified by cpu_wr.
REQ-008 SHALL have port flush, input, 1, a synchronous request to empty the FIFO and abort any wait.
REQ-009 SHALL have port err_clr, input, 1, which clears the sticky error flags.
REQ-010 SHALL have port latch_wr, output, 1, a one-cycle strobe to the sound-side command latch.
REQ-011 SHALL have port latch_din, output, 8, the command byte, valid from the latch_wr cycle and held until the next latch_wr.
REQ-012 SHALL have port snd_ack, input, 1, a one-cycle pulse when the sound CPU acknowledges the latch (port write clearing its ready flag).
REQ-013 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-014 SHALL have ports fifo_full and fifo_empty, output, 1 each, reporting the FIFO status.
REQ-015 SHALL have port count, output, 5, the FIFO occupancy (0..DEPTH).
REQ-016 SHALL have ports overflow and timeout_err, output, 1 each, sticky error flags.

Function
REQ-017 SHALL hold the commands in a DEPTH-entry circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-018 SHALL push cpu_din on cpu_wr when count<DEPTH, or when a pop occurs in the same cycle; otherwise it SHALL drop the byte, set overflow, and leave the FIFO unchanged.
REQ-019 SHALL implement state machine states IDLE, SEND and WAIT_ACK.
REQ-020 SHALL, in IDLE with the FIFO non-empty and paused=0, go to SEND on the next clk.
REQ-021 SHALL, in SEND, assert latch_wr for exactly one cycle, drive latch_din from the FIFO head in that cycle, pop the head, clear the timeout counter, and go to WAIT_ACK.
REQ-022 SHALL, in WAIT_ACK, go to IDLE on snd_ack; the earliest next latch_wr is therefore 2 cycles after the ack cycle.
REQ-023 SHALL, in WAIT_ACK with paused=0 and no ack, increment the timeout counter; on reaching ACK_TIMEOUT-1 it SHALL set timeout_err and go to IDLE.
REQ-024 SHALL accept snd_ack while paused, but the timeout counter SHALL hold.
REQ-025 SHALL ignore snd_ack outside WAIT_ACK, including an ack arriving in the SEND cycle.
REQ-026 SHALL keep the minimum latency from cpu_wr into an empty, idle, unpaused block to latch_wr at 2 cycles (push cycle, then IDLE->SEND).
REQ-027 SHALL, on flush, zero both pointers and count, return to IDLE, and suppress latch_wr in that cycle; latch_din keeps its value, and a cpu_wr in the same cycle is dropped without setting overflow.
REQ-028 SHALL give err_clr priority below a new error event in the same cycle (the flag stays set).
REQ-029 SHALL derive busy, fifo_full, fifo_empty and count from registered state only (no combinational path from inputs).

Reset
REQ-030 SHALL, while reset_n=0, asynchronously force: state IDLE, pointers 0, count 0, latch_wr 0, latch_din 8'h00, overflow 0, timeout_err 0, timeout counter 0, busy 0, fifo_empty 1, fifo_full 0.
REQ-031 SHALL release synchronously on the first clk edge after reset_n rises; a reset during WAIT_ACK discards the pending command and all queued commands.

Verification
REQ-032 SHALL be verified with this scenario: cpu_wr with 8'h12 into an idle block -> latch_wr high exactly 2 cycles later with latch_din=8'h12; busy high until snd_ack, IDLE on the following cycle.
REQ-033 SHALL be verified with this scenario: 5 back-to-back writes 8'h01..8'h05 with DEPTH=4 and no ack -> first byte issued, bytes 02..05 queued, no overflow; a 6th write sets overflow; acks then release 02,03,04,05 in order.
REQ-034 SHALL be verified with this scenario: no snd_ack after a command, ACK_TIMEOUT=16 -> timeout_err set 16 cycles after latch_wr, state IDLE, next queued byte sent; paused=1 mid-wait extends the timeout by the paused cycles.
REQ-035 SHALL be verified with this scenario: FIFO full, with cpu_wr coinciding with the SEND pop -> byte accepted, count stays 4, overflow stays 0.
REQ-036 SHALL be verified with this scenario: flush asserted during WAIT_ACK with 3 queued -> count 0, busy 0 next cycle, no further latch_wr, latch_din unchanged.
REQ-037 SHALL be verified with this scenario: reset_n dropped between clock edges in WAIT_ACK -> outputs reach their reset values immediately without a clk edge; nothing is sent after release until a new cpu_wr.
